// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first, rippled carry,
// signed-overflow flag and valid/ready handshakes on both sides.
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;
    logic             w_msb_cin;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) w_next = CALC;
                else          w_next = IDLE;
            end
            CALC: begin
                if (w_last) w_next = DONE;
                else        w_next = CALC;
            end
            DONE: begin
                if (out_ready) w_next = IDLE;
                else           w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            CALC:    in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // One chunk of the ripple add; the final chunk's MSB carries give the overflow flag
    always_comb begin
        w_a_chunk  = r_a[r_cnt*CHUNK +: CHUNK];
        w_b_chunk  = r_b[r_cnt*CHUNK +: CHUNK];
        w_chunk    = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_sum_next = r_sum;
        w_sum_next[r_cnt*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
        w_last     = (r_cnt == LAST_CNT);
        w_msb_cin  = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk[CHUNK-1];
    end

    // Operand capture, chunk accumulation and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_s     <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= cin ^ sub;
                        r_cnt   <= {CW{1'b0}};
                        r_sum   <= {WIDTH{1'b0}};
                    end
                end
                CALC: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk[CHUNK];
                    r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        r_s    <= w_sum_next;
                        r_cout <= w_chunk[CHUNK];
                        r_ovf  <= w_msb_cin ^ w_chunk[CHUNK];
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_addsub.sv
// Randomised self-checking bench for chunked_addsub at 32/8, 16/16 and 64/4,
// compared against a whole-word arithmetic reference model.
module tb_chunked_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        d32_in_valid = 1'b0, d32_in_ready, d32_cin = 1'b0, d32_sub = 1'b0;
    logic        d32_out_valid, d32_out_ready = 1'b0, d32_cout, d32_ovf;
    logic [31:0] d32_a = 32'd0, d32_b = 32'd0, d32_s;

    logic        d16_in_valid = 1'b0, d16_in_ready, d16_cin = 1'b0, d16_sub = 1'b0;
    logic        d16_out_valid, d16_out_ready = 1'b0, d16_cout, d16_ovf;
    logic [15:0] d16_a = 16'd0, d16_b = 16'd0, d16_s;

    logic        d64_in_valid = 1'b0, d64_in_ready, d64_cin = 1'b0, d64_sub = 1'b0;
    logic        d64_out_valid, d64_out_ready = 1'b0, d64_cout, d64_ovf;
    logic [63:0] d64_a = 64'd0, d64_b = 64'd0, d64_s;

    chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
        .a(d32_a), .b(d32_b), .cin(d32_cin), .sub(d32_sub), .out_valid(d32_out_valid),
        .out_ready(d32_out_ready), .s(d32_s), .cout(d32_cout), .ovf(d32_ovf));

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .a(d16_a), .b(d16_b), .cin(d16_cin), .sub(d16_sub), .out_valid(d16_out_valid),
        .out_ready(d16_out_ready), .s(d16_s), .cout(d16_cout), .ovf(d16_ovf));

    chunked_addsub #(.WIDTH(64), .CHUNK(4)) u_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(d64_in_valid), .in_ready(d64_in_ready),
        .a(d64_a), .b(d64_b), .cin(d64_cin), .sub(d64_sub), .out_valid(d64_out_valid),
        .out_ready(d64_out_ready), .s(d64_s), .cout(d64_cout), .ovf(d64_ovf));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a+b+cin or a-b-cin on w-bit words; cout = carry (add) or no-borrow (sub);
    // ovf = exact signed result outside the w-bit two's-complement range.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub,
                                  output logic [63:0] s, output logic cout, output logic ovf);
        logic [63:0]        mask;
        logic [65:0]        ua, ub, uc, t;
        logic signed [67:0] sa, sb, sc, sr, lim;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        ua = {2'b00, a & mask};
        ub = {2'b00, b & mask};
        uc = {65'd0, cin};
        if (sub) begin
            cout = (ua >= ub + uc);
            t    = ua - ub - uc;
        end else begin
            t    = ua + ub + uc;
            cout = t[w];
        end
        s  = t[63:0] & mask;
        sa = $signed({2'b00, ua});
        sb = $signed({2'b00, ub});
        sc = $signed({67'd0, cin});
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        sr  = sub ? (sa - sb - sc) : (sa + sb + sc);
        lim = 68'sd1 <<< (w - 1);
        ovf = (sr >= lim) || (sr < -lim);
    endfunction

    task automatic wait_out32(output int lat);
        lat = 0;
        while (!d32_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        for (int i = 0; i < 100 && !d32_in_ready; i++) @(negedge clk);
        d32_a = a; d32_b = b; d32_cin = cin; d32_sub = sub; d32_in_valid = 1'b1;
        @(negedge clk);
        d32_in_valid = 1'b0;
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        logic [63:0] es;
        logic        ec, eo;
        int          lat;
        model(32, {32'd0, a}, {32'd0, b}, cin, sub, es, ec, eo);
        start32(a, b, cin, sub);
        wait_out32(lat);
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_s"}, {32'd0, d32_s}, es);
        check({tag, "_cout"}, {63'd0, d32_cout}, {63'd0, ec});
        check({tag, "_ovf"}, {63'd0, d32_ovf}, {63'd0, eo});
        d32_out_ready = 1'b1;
        @(negedge clk);
        d32_out_ready = 1'b0;
        check({tag, "_ovalid_clr"}, {63'd0, d32_out_valid}, 64'd0);
        check({tag, "_s_hold"}, {32'd0, d32_s}, es);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic [63:0] es;
        logic        ec, eo;
        int          lat;
        model(16, {48'd0, a}, {48'd0, b}, cin, sub, es, ec, eo);
        for (int i = 0; i < 100 && !d16_in_ready; i++) @(negedge clk);
        d16_a = a; d16_b = b; d16_cin = cin; d16_sub = sub; d16_in_valid = 1'b1;
        @(negedge clk);
        d16_in_valid = 1'b0;
        lat = 0;
        while (!d16_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("w16_lat", 64'(lat), 64'd1);
        check("w16_s", {48'd0, d16_s}, es);
        check("w16_cout_ovf", {62'd0, d16_cout, d16_ovf}, {62'd0, ec, eo});
        d16_out_ready = 1'b1;
        @(negedge clk);
        d16_out_ready = 1'b0;
    endtask

    task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        logic [63:0] es;
        logic        ec, eo;
        int          lat;
        model(64, a, b, cin, sub, es, ec, eo);
        for (int i = 0; i < 100 && !d64_in_ready; i++) @(negedge clk);
        d64_a = a; d64_b = b; d64_cin = cin; d64_sub = sub; d64_in_valid = 1'b1;
        @(negedge clk);
        d64_in_valid = 1'b0;
        lat = 0;
        while (!d64_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("w64_lat", 64'(lat), 64'd16);
        check("w64_s", d64_s, es);
        check("w64_cout_ovf", {62'd0, d64_cout, d64_ovf}, {62'd0, ec, eo});
        d64_out_ready = 1'b1;
        @(negedge clk);
        d64_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, d32_in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, d32_out_valid}, 64'd0);
        check("rst_s", {32'd0, d32_s}, 64'd0);
        check("rst_cout_ovf", {62'd0, d32_cout, d32_ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run32("add_basic", 32'd5, 32'd10, 1'b0, 1'b0);
        run32("add_allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run32("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        run32("sub_neg", 32'd15, 32'd20, 1'b0, 1'b1);
        run32("sub_pos", 32'd20, 32'd15, 1'b0, 1'b1);
        run32("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1);
        run32("sub_borrow_in", 32'd20, 32'd15, 1'b1, 1'b1);

        // Backpressure: result held while new requests are offered and ignored
        start32(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_out32(lat);
        d32_a = 32'h1111_1111; d32_b = 32'h2222_2222; d32_cin = 1'b0; d32_sub = 1'b0;
        d32_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s", {32'd0, d32_s}, 64'h8000_0000);
            check("bp_flags", {61'd0, d32_out_valid, d32_in_ready, d32_ovf}, 64'b101);
        end
        d32_out_ready = 1'b1;
        @(negedge clk);
        d32_out_ready = 1'b0;
        check("bp_release", {62'd0, d32_out_valid, d32_in_ready}, 64'b01);
        @(negedge clk);
        d32_in_valid = 1'b0;
        check("bp_accepted", {63'd0, d32_in_ready}, 64'd0);
        wait_out32(lat);
        check("bp_new_lat", 64'(lat), 64'd4);
        check("bp_new_s", {32'd0, d32_s}, 64'h3333_3333);
        d32_out_ready = 1'b1;
        @(negedge clk);
        d32_out_ready = 1'b0;

        // Asynchronous reset while the third chunk is pending
        run32("pre_rst", 32'd20, 32'd15, 1'b0, 1'b1);
        start32(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, d32_out_valid}, 64'd0);
        check("arst_s", {32'd0, d32_s}, 64'd0);
        check("arst_cout", {63'd0, d32_cout}, 64'd0);
        check("arst_in_ready", {63'd0, d32_in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {63'd0, d32_in_ready}, 64'd1);
        run32("post_rst", 32'd100000, 32'd200000, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++)
            run32("rand32", $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        for (int i = 0; i < 1000; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
        for (int i = 0; i < 1000; i++)
            run64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'($urandom_range(1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
